// File: rtl/pausible_clock_arbiter.sv
// Round-robin arbiter sharing one four-phase req/grant port of the pausible clock
// synchronizer among NUM_REQ requesters, with a per-grant hold limit.
module pausible_clock_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MAX_HOLD    = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic                                             clock,
   input  logic                                             rst,
   input  logic [NUM_REQ-1:0]                               req_in,
   output logic [NUM_REQ-1:0]                               gnt_out,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
   output logic                                             pc_req,
   input  logic                                             pc_grant,
   output logic                                             busy,
   output logic                                             timeout
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_REL} state_t;

   state_t               state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                 gs;
   logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]   mask_reg, mask_next, mask_set;
   logic [NUM_REQ-1:0]   elig;
   logic [OW-1:0]        owner_reg, owner_next;
   logic [OW-1:0]        ptr_reg, ptr_next;
   logic [OW-1:0]        pick;
   logic                 pick_valid;
   logic [OW-1:0]        rot_idx [NUM_REQ];
   logic                 pc_req_reg, pc_req_next;
   logic                 timeout_reg, timeout_next;
   logic [15:0]          hold_reg, hold_next;
   logic                 owner_req;

   always_ff @(posedge clock) begin
      if (rst) sync_reg <= '0;
      else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], pc_grant};
   end

   assign gs        = sync_reg[SYNC_STAGES-1];
   assign elig      = req_in & ~mask_reg;
   assign owner_req = req_in[owner_reg];

   // rot_idx[gi] is the requester visited gi steps after ptr; mask bits drop with the request.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         logic [OW:0] sum;
         assign sum         = {1'b0, ptr_reg} + (OW+1)'(gi);
         assign rot_idx[gi] = (sum >= (OW+1)'(NUM_REQ)) ? OW'(sum - (OW+1)'(NUM_REQ)) : sum[OW-1:0];
         assign mask_next[gi] = (mask_reg[gi] | mask_set[gi]) & req_in[gi];
      end
   endgenerate

   // Scanning from the far end lets the nearest eligible index win.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (elig[rot_idx[k]]) begin
            pick       = rot_idx[k];
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      owner_next   = owner_reg;
      ptr_next     = ptr_reg;
      pc_req_next  = pc_req_reg;
      timeout_next = 1'b0;
      hold_next    = hold_reg;
      mask_set     = '0;
      case (state_reg)
         S_IDLE: begin
            if (pick_valid && !gs) begin
               owner_next  = pick;
               pc_req_next = 1'b1;
               state_next  = S_REQ;
            end
         end
         S_REQ: begin
            // An abandoned request wins over a grant arriving in the same cycle.
            if (!owner_req) begin
               pc_req_next = 1'b0;
               state_next  = S_REL;
            end else if (gs) begin
               gnt_next            = '0;
               gnt_next[owner_reg] = 1'b1;
               hold_next           = '0;
               state_next          = S_OWN;
            end
         end
         S_OWN: begin
            hold_next = hold_reg + 16'd1;
            if (!owner_req) begin
               gnt_next    = '0;
               pc_req_next = 1'b0;
               state_next  = S_REL;
            end else if (hold_reg == HOLD_LAST) begin
               gnt_next            = '0;
               pc_req_next         = 1'b0;
               timeout_next        = 1'b1;
               mask_set[owner_reg] = 1'b1;
               state_next          = S_REL;
            end
         end
         S_REL: begin
            if (!gs) begin
               ptr_next   = (owner_reg == OW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         gnt_reg     <= '0;
         mask_reg    <= '0;
         owner_reg   <= '0;
         ptr_reg     <= '0;
         pc_req_reg  <= 1'b0;
         timeout_reg <= 1'b0;
         hold_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         mask_reg    <= mask_next;
         owner_reg   <= owner_next;
         ptr_reg     <= ptr_next;
         pc_req_reg  <= pc_req_next;
         timeout_reg <= timeout_next;
         hold_reg    <= hold_next;
      end
   end

   assign gnt_out = gnt_reg;
   assign owner   = owner_reg;
   assign pc_req  = pc_req_reg;
   assign timeout = timeout_reg;
   assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pausible_clock_arbiter.sv
// Directed bench for pausible_clock_arbiter: a cycle model built from the grant rules
// is compared every cycle, plus hand-computed latencies and sequences.
module tb_pausible_clock_arbiter;

   localparam int N  = 4;
   localparam int MH = 8;
   localparam int SS = 2;
   localparam int P_IDLE = 0, P_REQ = 1, P_OWN = 2, P_REL = 3;

   logic         clock = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_in = '0;
   logic         pc_grant = 1'b0;
   logic [N-1:0] gnt_out;
   logic [1:0]   owner;
   logic         pc_req, busy, timeout;

   int err_cnt = 0;
   int chk_cnt = 0;
   bit chk_en = 0;
   bit auto_resp = 1;
   int resp_cnt = 0;

   always #5 clock = ~clock;

   pausible_clock_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH), .SYNC_STAGES(SS)) dut (
      .clock(clock), .rst(rst), .req_in(req_in), .gnt_out(gnt_out), .owner(owner),
      .pc_req(pc_req), .pc_grant(pc_grant), .busy(busy), .timeout(timeout)
   );

   // Model: phase plus grant age (cycles the grant has been visible), grant delay line as a queue.
   int           m_phase, m_owner, m_ptr, m_age;
   logic [N-1:0] m_gnt, m_mask, m_elig, m_set;
   bit           m_pc_req, m_timeout, m_gs, m_found;
   bit           gh[$];

   always @(posedge clock) begin
      if (rst) begin
         m_phase = P_IDLE; m_owner = 0; m_ptr = 0; m_age = 0;
         m_gnt = '0; m_mask = '0; m_pc_req = 0; m_timeout = 0; m_gs = 0;
         gh.delete();
         chk_en = 1;
      end else begin
         m_timeout = 0;
         m_set = '0;
         m_elig = req_in & ~m_mask;
         case (m_phase)
            P_IDLE: if (m_elig != 0 && !m_gs) begin
               m_found = 0;
               for (int k = 0; k < N; k++)
                  if (!m_found && m_elig[(m_ptr + k) % N]) begin
                     m_owner = (m_ptr + k) % N;
                     m_found = 1;
                  end
               m_pc_req = 1;
               m_phase = P_REQ;
            end
            P_REQ: if (!req_in[m_owner]) begin
               m_pc_req = 0; m_phase = P_REL;
            end else if (m_gs) begin
               m_gnt = '0; m_gnt[m_owner] = 1'b1; m_age = 1; m_phase = P_OWN;
            end
            P_OWN: if (!req_in[m_owner]) begin
               m_gnt = '0; m_pc_req = 0; m_phase = P_REL;
            end else if (m_age >= MH) begin
               m_gnt = '0; m_pc_req = 0; m_timeout = 1; m_set[m_owner] = 1'b1; m_phase = P_REL;
            end else begin
               m_age++;
            end
            default: if (!m_gs) begin
               m_ptr = (m_owner + 1) % N; m_phase = P_IDLE;
            end
         endcase
         m_mask = (m_mask | m_set) & req_in;
         gh.push_front(pc_grant);
         if (gh.size() > SS) void'(gh.pop_back());
         m_gs = (gh.size() == SS) ? gh[SS-1] : 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("gnt_out", 32'(gnt_out), 32'(m_gnt));
         check("pc_req", 32'(pc_req), 32'(m_pc_req));
         check("owner", 32'(owner), m_owner);
         check("busy", 32'(busy), (m_phase != P_IDLE) ? 1 : 0);
         check("timeout", 32'(timeout), 32'(m_timeout));
         check("onehot", ($countones(gnt_out) <= 1) ? 1 : 0, 1);
      end
   end

   // Emulated synchronizer: grant 3 cycles after request, drop as soon as request drops.
   task automatic step();
      @(negedge clock);
      if (auto_resp) begin
         if (pc_req) begin
            resp_cnt++;
            if (resp_cnt >= 3) pc_grant = 1'b1;
         end else begin
            resp_cnt = 0;
            pc_grant = 1'b0;
         end
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 60) begin step(); k++; end
      check("idle_reached", 32'(busy), 0);
   endtask

   task automatic wait_gnt(input int b);
      int k = 0;
      while (!gnt_out[b] && k < 60) begin step(); k++; end
      check("grant_seen", 32'(gnt_out[b]), 1);
   endtask

   initial begin
      int k, hc, nseq, cnt, tcount, regrant, gseen;
      int seq[5];
      int exp_seq[5];
      logic [N-1:0] nxt, prev;
      exp_seq = '{0, 1, 2, 3, 0};

      // Reset
      repeat (3) step();
      check("rst_gnt", 32'(gnt_out), 0);
      check("rst_pc_req", 32'(pc_req), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      step();
      check("rst_owner", 32'(owner), 0);
      check("rst_timeout", 32'(timeout), 0);

      // Single requester
      req_in = 4'b0001;
      step();
      check("pc_req_latency", 32'(pc_req), 1);
      check("busy_rise", 32'(busy), 1);
      k = 0;
      while (!pc_grant && k < 20) begin step(); k++; end
      k = 0;
      do begin step(); k++; end while (gnt_out == 0 && k < 20);
      check("grant_latency", k, SS + 1);
      check("gnt_single", 32'(gnt_out), 1);
      repeat (2) step();
      req_in = 4'b0000;
      step();
      check("release_gnt", 32'(gnt_out), 0);
      check("release_pc_req", 32'(pc_req), 0);
      wait_idle();

      // Round robin with short holds
      rst = 1'b1; step(); rst = 1'b0;
      hc = 0; nseq = 0; prev = '0;
      for (int s = 0; s < 300 && nseq < 5; s++) begin
         nxt = '1;
         if (gnt_out != 0) begin
            hc++;
            if (hc == 2) nxt = ~gnt_out;
         end else hc = 0;
         req_in = nxt;
         step();
         if (gnt_out != 0 && prev == 0) begin
            for (int i = 0; i < N; i++) if (gnt_out[i]) seq[nseq] = i;
            nseq++;
         end
         prev = gnt_out;
      end
      check("rr_count", nseq, 5);
      for (int i = 0; i < 5; i++) check($sformatf("rr_owner%0d", i), seq[i], exp_seq[i]);
      req_in = '0;
      wait_idle();

      // Timeout on requester 2
      req_in = 4'b0100;
      wait_gnt(2);
      cnt = 0; tcount = 0;
      while (gnt_out[2] && cnt < 40) begin cnt++; step(); tcount += int'(timeout); end
      check("hold_len", cnt, MH);
      regrant = 0;
      repeat (30) begin step(); tcount += int'(timeout); regrant += int'(gnt_out[2]); end
      check("timeout_pulses", tcount, 1);
      check("masked_no_regrant", regrant, 0);
      req_in = 4'b0000; step();
      req_in = 4'b0100;
      wait_gnt(2);
      req_in = '0;
      wait_idle();

      // Release coinciding with the hold limit
      req_in = 4'b0010;
      wait_gnt(1);
      repeat (MH - 1) step();
      check("still_held", 32'(gnt_out), 32'h2);
      req_in = 4'b0000;
      tcount = 0;
      repeat (4) begin step(); tcount += int'(timeout); end
      check("coincident_no_timeout", tcount, 0);
      wait_idle();

      // Abandon in REQ
      auto_resp = 0; pc_grant = 1'b0;
      req_in = 4'b0010;
      step();
      check("abandon_pc_req", 32'(pc_req), 1);
      pc_grant = 1'b1;
      step();
      req_in = 4'b0000;
      gseen = 0;
      repeat (6) begin step(); gseen |= int'(gnt_out != 0); end
      check("abandon_busy", 32'(busy), 1);
      check("abandon_pc_req_low", 32'(pc_req), 0);
      pc_grant = 1'b0;
      k = 0;
      do begin step(); k++; end while (busy && k < 20);
      check("rel_exit_latency", k, SS + 1);
      check("abandon_no_grant", gseen, 0);

      // Reset mid-OWN with pc_grant still high
      auto_resp = 1; resp_cnt = 0;
      req_in = 4'b0001;
      wait_gnt(0);
      auto_resp = 0;
      rst = 1'b1; req_in = 4'b0000;
      step();
      check("midrst_gnt", 32'(gnt_out), 0);
      check("midrst_pc_req", 32'(pc_req), 0);
      check("midrst_busy", 32'(busy), 0);
      rst = 1'b0;
      repeat (4) step();
      req_in = 4'b0001;
      k = 0;
      repeat (4) begin step(); k += int'(pc_req); end
      check("held_off", k, 0);
      pc_grant = 1'b0;
      k = 0;
      do begin step(); k++; end while (!pc_req && k < 20);
      check("reissue_latency", k, SS + 1);
      auto_resp = 1; resp_cnt = 0;
      wait_gnt(0);
      req_in = '0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", err_cnt);
      $fatal(1, "watchdog");
   end

endmodule
